ahb_lite_master: RTL and testbench
==================================

# ahb_lite_master

Single-clock AHB-Lite bus initiator that converts the core's valid/ready load/store requests into AHB SINGLE transfers. It drives HADDR/HTRANS/HWDATA, overlaps each address phase with the previous data phase, honours HREADY wait states and two-cycle ERROR responses, and returns lane-aligned read data. It sits between the RV32I load/store unit and the AHB interconnect, facing zero-wait memory slaves and slaves with wait states alike.

## Interface
- ADDR_WIDTH, 32, address width; data width fixed at 32.
- HPROT_VAL, 4'b0011, constant HPROT (non-cacheable privileged data).
- Clocking: one clock (HCLK). Reset (HRESET) is synchronous and active-high.
- HCLK  in  1  clock, all state on rising edge
- HRESET  in  1  synchronous active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  request accepted on this edge when both high
- req_addr  in  ADDR_WIDTH  byte address
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_wdata  in  32  store data, LSB-justified
- rsp_valid  out  1  one-cycle response strobe; no backpressure
- rsp_rdata  out  32  load data, LSB-justified, zero-extended (0 for stores/errors)
- rsp_err  out  1  bus ERROR or misaligned/illegal request
- HADDR  out  ADDR_WIDTH, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HWDATA  out  32
- HBURST  out  3  constant 3'b000; HPROT  out  4  HPROT_VAL; HMASTLOCK  out  1  constant 0
- HRDATA  in  32, HREADY  in  1, HRESP  in  1  (0=OKAY, 1=ERROR)

## Operation
- Two internal slots. AP holds the address-phase transfer and drives HADDR/HWRITE/HSIZE/HTRANS. DP holds the data-phase transfer and drives HWDATA.
- HTRANS = NONSEQ (2'b10) when AP is valid and not in an ERROR first cycle; otherwise IDLE (2'b00). SEQ and BUSY are never issued.
- On an edge with HREADY=1:
  - DP <= AP (or empty if AP is empty).
  - AP <= the accepted request, or empty.
  - If DP was valid, the response registers load.
- On an edge with HREADY=0, AP and DP hold.
- req_ready = HREADY & ~(HRESP & ~HREADY). For misaligned or illegal requests, req_ready additionally requires AP and DP both empty.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; size 3 is illegal. These requests are not put on the bus. They are accepted only when drained, and produce rsp_valid=1, rsp_err=1, rsp_rdata=0 on the next cycle.
- Lane = addr[1:0].
  - HWDATA = DP wdata << (8*lane).
  - Load response: rsp_rdata = (HRDATA >> 8*lane) masked to size, zero-extended. Sign extension is the core's job.
- HSIZE = {1'b0, req_size}. HADDR carries the full unmodified byte address.
- ERROR handling:
  - First cycle (HRESP=1, HREADY=0): HTRANS is forced IDLE combinationally, which cancels AP.
  - Second cycle (HRESP=1, HREADY=1): the DP response completes with rsp_err=1 and rsp_rdata=0. AP then re-presents its transfer, not lost and not reordered.
- Responses are returned strictly in request order, one per accepted request.

## Timing
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, AP/DP empty.
- Reset mid-transfer: all outstanding transfers are dropped and no responses are issued. HTRANS=IDLE on the cycle after the reset edge.
- Latency with zero wait states: request accepted at edge E0, address phase in cycle E0..E1, data phase in E1..E2, rsp_valid high for cycle E2..E3. That is 2 edges from acceptance to response.
- Each data-phase wait cycle adds exactly 1 cycle. Throughput is 1 transfer per cycle while HREADY=1.
- HREADY, HRESP -> req_ready and HTRANS are the only combinational paths. All other outputs are registered.

## Test plan
- Word store then load, zero wait:
  - Stimulus: store 0xDEADBEEF to 0x100, then load 0x100 back-to-back.
  - Required: HTRANS NONSEQ on 2 consecutive cycles; HWDATA=0xDEADBEEF in the cycle after the store address; load response has rsp_rdata=0xDEADBEEF, rsp_err=0, 2 edges after acceptance.
- Byte and half lanes:
  - Stimulus: store byte 0xAB to 0x103.
  - Required: HSIZE=0, HWDATA=0xAB000000.
  - Stimulus: load half at 0x102 with HRDATA=0x1234ABCD.
  - Required: rsp_rdata=0x00001234.
- Wait states:
  - Stimulus: slave holds HREADY=0 for 3 cycles during a load data phase while a second request is pending.
  - Required: AP is held with HADDR stable; req_ready=0; the first response arrives 3 cycles late; the second follows 1 cycle later.
- ERROR response:
  - Stimulus: a load to 0x8000 receives ERROR while a load to 0x104 sits in AP.
  - Required: HTRANS=IDLE in the first error cycle; rsp_err=1 with rsp_rdata=0 for 0x8000; 0x104 is re-issued and returns OKAY.
- Misaligned request:
  - Stimulus: word load to 0x102 issued while one transfer is outstanding.
  - Required: the request is not accepted until drained; no bus transfer occurs; the next cycle gives rsp_valid=1, rsp_err=1.
- Reset during data phase:
  - Stimulus: assert HRESET for 1 cycle while a store is in its data phase.
  - Required: no rsp_valid; all outputs return to reset values; a following request completes normally.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator: core valid/ready load/store requests -> NONSEQ SINGLE transfers.
// Latency: 2 edges from acceptance to rsp_valid with zero wait states; +1 per HREADY=0 data-phase cycle.
// Backpressure: req_ready follows HREADY (low in ERROR first cycle); misaligned requests wait for an empty pipe.
module ahb_lite_master #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [31:0]           HWDATA,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Address-phase slot
  logic                  ap_vld_q,   ap_vld_d;
  logic [ADDR_WIDTH-1:0] ap_addr_q,  ap_addr_d;
  logic                  ap_write_q, ap_write_d;
  logic [1:0]            ap_size_q,  ap_size_d;
  logic [31:0]           ap_wdata_q, ap_wdata_d;

  // Data-phase slot (only what the data phase still needs)
  logic                  dp_vld_q,   dp_vld_d;
  logic [1:0]            dp_lane_q,  dp_lane_d;
  logic                  dp_write_q, dp_write_d;
  logic [1:0]            dp_size_q,  dp_size_d;
  logic [31:0]           hwdata_q,   hwdata_d;

  // Response registers
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic        req_misaligned;
  logic        err_first;
  logic        drained;
  logic        accept;
  logic        accept_bus;
  logic        accept_bad;
  logic [31:0] rd_shifted;
  logic [31:0] rd_word;

  // Request qualification, handshake and the two combinational bus paths
  always_comb begin
    req_misaligned = (req_size == 2'd3)
                   | ((req_size == 2'd1) & req_addr[0])
                   | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
    err_first  = HRESP & ~HREADY;
    drained    = ~ap_vld_q & ~dp_vld_q;
    // Bad requests bypass the bus, so they may only enter an empty pipe to keep responses in order
    req_ready  = HREADY & ~err_first & (~req_misaligned | drained);
    accept     = req_valid & req_ready;
    accept_bus = accept & ~req_misaligned;
    accept_bad = accept & req_misaligned;
    // ERROR first cycle cancels the pending address phase; it is re-presented next cycle
    HTRANS     = (ap_vld_q & ~err_first) ? TRANS_NONSEQ : TRANS_IDLE;
  end

  // Load data lane extraction, zero-extended to the access size
  always_comb begin
    rd_shifted = HRDATA >> {dp_lane_q, 3'b000};
    case (dp_size_q)
      2'd0:    rd_word = {24'h0, rd_shifted[7:0]};
      2'd1:    rd_word = {16'h0, rd_shifted[15:0]};
      default: rd_word = rd_shifted;
    endcase
  end

  // Pipeline advance: everything moves only on HREADY=1 edges
  always_comb begin
    ap_vld_d    = ap_vld_q;
    ap_addr_d   = ap_addr_q;
    ap_write_d  = ap_write_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    dp_vld_d    = dp_vld_q;
    dp_lane_d   = dp_lane_q;
    dp_write_d  = dp_write_q;
    dp_size_d   = dp_size_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;

    if (HREADY) begin
      dp_vld_d   = ap_vld_q;
      dp_lane_d  = ap_addr_q[1:0];
      dp_write_d = ap_write_q;
      dp_size_d  = ap_size_q;
      hwdata_d   = ap_vld_q ? (ap_wdata_q << {ap_addr_q[1:0], 3'b000}) : 32'h0;

      ap_vld_d = accept_bus;
      if (accept_bus) begin
        ap_addr_d  = req_addr;
        ap_write_d = req_write;
        ap_size_d  = req_size;
        ap_wdata_d = req_wdata;
      end

      if (dp_vld_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = HRESP;
        rsp_rdata_d = (HRESP | dp_write_q) ? 32'h0 : rd_word;
      end else if (accept_bad) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset drops all outstanding transfers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_vld_q    <= 1'b0;
      ap_addr_q   <= '0;
      ap_write_q  <= 1'b0;
      ap_size_q   <= 2'd0;
      ap_wdata_q  <= 32'h0;
      dp_vld_q    <= 1'b0;
      dp_lane_q   <= 2'd0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= 2'd0;
      hwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      ap_vld_q    <= ap_vld_d;
      ap_addr_q   <= ap_addr_d;
      ap_write_q  <= ap_write_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_vld_q    <= dp_vld_d;
      dp_lane_q   <= dp_lane_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HADDR     = ap_addr_q;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = {1'b0, ap_size_q};
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: random and directed requests against a bus slave model and
// an in-order reference memory; responses, handshake and bus phases checked every cycle.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  req_t send_q[$];
  req_t rsp_q[$];
  req_t bus_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] sl_mem  [16];
  int   outstanding = 0;
  bit   exp_rsp_now = 0;
  bit   reset_now = 0;
  bit   chk_rst = 0;
  bit   rand_mode = 0;
  int   force_wait = -1;

  bit   sl_vld = 0;
  req_t sl_tr;
  int   sl_wait = 0;
  bit   sl_errph = 0;

  int          acc_log[$];
  int          rsp_log[$];
  logic [31:0] rdata_log[$];
  logic        err_log[$];
  logic [31:0] last_hwdata = 32'h0;
  logic [2:0]  last_hsize = 3'd0;
  int          bus_cnt = 0;
  int          nonseq_run = 0;
  int          max_run = 0;
  int          err_idle_cnt = 0;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit misal(input req_t r);
    return (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) ||
           (r.size == 2'd2 && r.addr[1:0] != 2'b00);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  function automatic bit err_addr(input logic [31:0] a);
    return a[15];
  endfunction

  // Reference: responses in request order; stores take effect when their response is due
  task automatic ref_rsp(input req_t r, output logic [31:0] rd, output logic er);
    logic [31:0] w;
    int lane, n;
    rd = 32'h0;
    er = 1'b0;
    lane = int'(r.addr[1:0]);
    n = 1 << r.size;
    if (misal(r) || err_addr(r.addr)) begin
      er = 1'b1;
    end else if (r.write) begin
      w = ref_mem[widx(r.addr)];
      for (int b = 0; b < n; b++) w[8*(lane+b) +: 8] = r.wdata[8*b +: 8];
      ref_mem[widx(r.addr)] = w;
    end else begin
      w = ref_mem[widx(r.addr)] >> (8 * lane);
      rd = (n == 4) ? w : (w & ((32'h1 << (8 * n)) - 32'h1));
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); rsp_log.delete(); rdata_log.delete(); err_log.delete();
  endtask

  task automatic step();
    req_t cur, r;
    logic [31:0] erd, exp_hw, w;
    logic        eer, exp_ready;
    bit          done, exp_next;
    @(negedge HCLK);
    cyc++;
    if (chk_rst) begin
      check("rst_htrans", 32'(HTRANS), 32'h0);
      check("rst_haddr", HADDR, 32'h0);
      check("rst_hwrite", 32'(HWRITE), 32'h0);
      check("rst_hsize", 32'(HSIZE), 32'h0);
      check("rst_hwdata", HWDATA, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk_rst = 0;
    end
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_now));
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        r = rsp_q.pop_front();
        ref_rsp(r, erd, eer);
        check("rsp_rdata", rsp_rdata, erd);
        check("rsp_err", 32'(rsp_err), 32'(eer));
        rsp_log.push_back(cyc);
        rdata_log.push_back(rsp_rdata);
        err_log.push_back(rsp_err);
      end
    end

    if (reset_now) begin
      HRESET = 1'b1; req_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      #1;
      rsp_q.delete(); bus_q.delete();
      outstanding = 0; sl_vld = 0; exp_rsp_now = 0;
      reset_now = 0; chk_rst = 1;
      return;
    end
    HRESET = 1'b0;

    // Slave drives this cycle's data-phase response
    done = 0;
    HRDATA = $urandom;
    if (sl_vld) begin
      if (sl_wait > 0) begin
        HREADY = 1'b0; HRESP = 1'b0;
      end else if (err_addr(sl_tr.addr)) begin
        HRESP = 1'b1; HREADY = sl_errph; done = sl_errph;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0; done = 1;
        if (!sl_tr.write) HRDATA = sl_mem[widx(sl_tr.addr)];
      end
    end else begin
      HREADY = 1'b1; HRESP = 1'b0;
    end

    // Core side request
    if (send_q.size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
      req_valid = 1'b1;
      {req_addr, req_write, req_size, req_wdata} = send_q[0];
    end else begin
      req_valid = 1'b0;
      req_addr = $urandom; req_write = 1'($urandom); req_size = 2'($urandom); req_wdata = $urandom;
    end
    cur = {req_addr, req_write, req_size, req_wdata};
    #1;

    exp_ready = HREADY && !(HRESP && !HREADY) && (!misal(cur) || outstanding == 0);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("htrans_legal", 32'(HTRANS[0]), 32'h0);
    if (HRESP && !HREADY) begin
      check("htrans_err_idle", 32'(HTRANS), 32'h0);
      if (HTRANS == 2'b00) err_idle_cnt++;
    end
    if (req_valid && !req_ready) stall_cnt++;
    if (HTRANS == 2'b10) nonseq_run++; else nonseq_run = 0;
    if (nonseq_run > max_run) max_run = nonseq_run;

    // What happens at the coming edge
    exp_next = 0;
    if (done) begin
      if (sl_tr.write && !err_addr(sl_tr.addr)) begin
        exp_hw = sl_tr.wdata << (8 * int'(sl_tr.addr[1:0]));
        check("hwdata", HWDATA, exp_hw);
        last_hwdata = HWDATA;
        w = sl_mem[widx(sl_tr.addr)];
        for (int b = 0; b < (1 << sl_tr.size); b++)
          w[8*(int'(sl_tr.addr[1:0])+b) +: 8] = HWDATA[8*(int'(sl_tr.addr[1:0])+b) +: 8];
        sl_mem[widx(sl_tr.addr)] = w;
      end
      outstanding--;
      exp_next = 1;
      sl_vld = 0;
    end else if (sl_vld) begin
      if (sl_wait > 0) sl_wait--;
      else sl_errph = 1;
    end
    if (HREADY && HTRANS == 2'b10) begin
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 32'(HTRANS), 32'h0);
      end else begin
        r = bus_q.pop_front();
        check("haddr", HADDR, r.addr);
        check("hwrite", 32'(HWRITE), 32'(r.write));
        check("hsize", 32'(HSIZE), {29'h0, 1'b0, r.size});
        sl_vld = 1; sl_tr = r; sl_errph = 0;
        if (force_wait >= 0) begin sl_wait = force_wait; force_wait = -1; end
        else sl_wait = rand_mode ? int'($urandom_range(2)) : 0;
        last_hsize = HSIZE;
        bus_cnt++;
      end
    end
    if (req_valid && exp_ready) begin
      void'(send_q.pop_front());
      rsp_q.push_back(cur);
      acc_log.push_back(cyc);
      if (misal(cur)) exp_next = 1;
      else begin bus_q.push_back(cur); outstanding++; end
    end
    exp_rsp_now = exp_next;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((send_q.size() > 0 || rsp_q.size() > 0 || exp_rsp_now) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL timeout: %0d requests / %0d responses still pending after %0d cycles",
               send_q.size(), rsp_q.size(), budget);
    end
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                              input logic [31:0] wd);
    return {a, wr, sz, wd};
  endfunction

  initial begin
    int bus0, n;
    req_t r;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      sl_mem[i] = ref_mem[i];
    end

    reset_now = 1; step(); step(); step();
    check("hburst", 32'(HBURST), 32'h0);
    check("hprot", 32'(HPROT), 32'h3);
    check("hmastlock", 32'(HMASTLOCK), 32'h0);

    // Word store then load, zero wait
    clear_logs(); max_run = 0;
    send_q.push_back(mk(32'h100, 1'b1, 2'd2, 32'hDEADBEEF));
    send_q.push_back(mk(32'h100, 1'b0, 2'd2, 32'h0));
    run_idle(50);
    check("t1_nonseq_run", 32'(max_run >= 2), 32'h1);
    check("t1_hwdata", last_hwdata, 32'hDEADBEEF);
    if (rdata_log.size() == 2 && acc_log.size() == 2) begin
      check("t1_load_rdata", rdata_log[1], 32'hDEADBEEF);
      check("t1_load_err", 32'(err_log[1]), 32'h0);
      check("t1_latency", 32'((rsp_log[1] - 1) - acc_log[1]), 32'd2);
    end else check("t1_rsp_count", 32'(rdata_log.size()), 32'd2);

    // Byte store lane, half load lane
    send_q.push_back(mk(32'h103, 1'b1, 2'd0, 32'hAB));
    run_idle(50);
    check("t2_hsize", 32'(last_hsize), 32'h0);
    check("t2_hwdata", last_hwdata, 32'hAB000000);
    ref_mem[0] = 32'h1234ABCD; sl_mem[0] = 32'h1234ABCD;
    clear_logs();
    send_q.push_back(mk(32'h102, 1'b0, 2'd1, 32'h0));
    run_idle(50);
    if (rdata_log.size() == 1) check("t2_half_rdata", rdata_log[0], 32'h00001234);
    else check("t2_rsp_count", 32'(rdata_log.size()), 32'd1);

    // Wait states on a load data phase with requests queued behind
    clear_logs(); stall_cnt = 0; force_wait = 3;
    send_q.push_back(mk(32'h108, 1'b0, 2'd2, 32'h0));
    send_q.push_back(mk(32'h10C, 1'b0, 2'd2, 32'h0));
    send_q.push_back(mk(32'h110, 1'b0, 2'd2, 32'h0));
    run_idle(60);
    check("t3_stalls", 32'(stall_cnt >= 3), 32'h1);
    if (rsp_log.size() == 3) begin
      check("t3_first_latency", 32'((rsp_log[0] - 1) - acc_log[0]), 32'd5);
      check("t3_second_gap", 32'(rsp_log[1] - rsp_log[0]), 32'd1);
    end else check("t3_rsp_count", 32'(rsp_log.size()), 32'd3);

    // ERROR response with the next load sitting in the address phase
    ref_mem[1] = 32'hCAFE0104; sl_mem[1] = 32'hCAFE0104;
    clear_logs(); err_idle_cnt = 0;
    send_q.push_back(mk(32'h8000, 1'b0, 2'd2, 32'h0));
    send_q.push_back(mk(32'h104, 1'b0, 2'd2, 32'h0));
    run_idle(60);
    check("t4_err_idle_seen", 32'(err_idle_cnt >= 1), 32'h1);
    if (rdata_log.size() == 2) begin
      check("t4_err_flag", 32'(err_log[0]), 32'h1);
      check("t4_err_rdata", rdata_log[0], 32'h0);
      check("t4_reissue_err", 32'(err_log[1]), 32'h0);
      check("t4_reissue_rdata", rdata_log[1], 32'hCAFE0104);
    end else check("t4_rsp_count", 32'(rdata_log.size()), 32'd2);

    // Misaligned word load behind an outstanding transfer
    clear_logs(); bus0 = bus_cnt;
    send_q.push_back(mk(32'h108, 1'b0, 2'd2, 32'h0));
    send_q.push_back(mk(32'h102, 1'b0, 2'd2, 32'h0));
    run_idle(60);
    check("t5_bus_transfers", 32'(bus_cnt - bus0), 32'd1);
    if (rsp_log.size() == 2 && acc_log.size() == 2) begin
      check("t5_wait_drain", 32'(acc_log[1] - acc_log[0]), 32'd3);
      check("t5_next_cycle", 32'((rsp_log[1] - 1) - acc_log[1]), 32'd0);
      check("t5_err", 32'(err_log[1]), 32'h1);
      check("t5_rdata", rdata_log[1], 32'h0);
    end else check("t5_rsp_count", 32'(rsp_log.size()), 32'd2);

    // Reset while a store is in its data phase
    ref_mem[3] = 32'h0BADF00D; sl_mem[3] = 32'h0BADF00D;
    clear_logs();
    send_q.push_back(mk(32'h10C, 1'b1, 2'd2, 32'h11111111));
    step(); step();
    reset_now = 1; step();
    for (int i = 0; i < 4; i++) step();
    check("t6_no_rsp", 32'(rsp_log.size()), 32'd0);
    send_q.push_back(mk(32'h10C, 1'b0, 2'd2, 32'h0));
    run_idle(50);
    if (rdata_log.size() == 1) begin
      check("t6_after_rdata", rdata_log[0], 32'h0BADF00D);
      check("t6_after_err", 32'(err_log[0]), 32'h0);
    end else check("t6_rsp_count", 32'(rdata_log.size()), 32'd1);

    // Randomized traffic: sizes, lanes, error region, misalignment, wait states, gaps
    rand_mode = 1; clear_logs();
    n = 400;
    for (int i = 0; i < n; i++) begin
      r.size  = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
      r.addr  = (($urandom_range(9) == 0) ? 32'h8000 : 32'h100) +
                32'($urandom_range(15) * 4) + 32'($urandom_range(3));
      r.write = 1'($urandom);
      r.wdata = $urandom;
      send_q.push_back(r);
    end
    run_idle(8000);
    check("rand_rsp_count", 32'(rsp_log.size()), 32'(n));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
